vpu_sp_ram_arbiter: RTL and testbench

//  Shares the single-port sprite/BG-parameter RAM between two requesters:
//  - the VPU parameter loader/sprite fetch (read-only, timing-critical)
//  - the CPU bus (read/write)
//  VPU wins during active display. The CPU wins during vblank. A starvation

---
 rtl/vpu_sp_ram_arbiter.sv | 135 +++++++++++++
 tb/tb_vpu_sp_ram_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_sp_ram_arbiter.sv
// Arbiter sharing the single-port sprite/BG-parameter RAM between the VPU fetch
// path and the CPU bus, with vblank priority, CPU starvation bound and VPU burst lock.
module vpu_sp_ram_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int BURST_LEN    = 20,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank,
  input  logic              vpu_req,
  input  logic              vpu_burst,
  input  logic [ADDR_W-1:0] vpu_addr,
  output logic              vpu_gnt,
  output logic              vpu_rvalid,
  output logic [DATA_W-1:0] vpu_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int BCW = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
  localparam int WCW = (CPU_MAX_WAIT > 2) ? $clog2(CPU_MAX_WAIT) : 1;
  localparam logic [BCW-1:0] BURST_LOAD = BCW'(BURST_LEN - 1);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(1);
  localparam logic [WCW-1:0] WAIT_MAX   = WCW'(CPU_MAX_WAIT - 1);

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [BCW-1:0] burst_cnt;
  logic [BCW-1:0] burst_cnt_nxt;
  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_cnt_nxt;

  // Grant decision and next-state; burst_cnt holds the beats still owed after the start grant.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    wait_cnt_nxt  = wait_cnt;
    vpu_gnt       = 1'b0;
    cpu_gnt       = 1'b0;
    case (state)
      ARB: begin
        if (vblank) begin
          cpu_gnt = cpu_req;
          vpu_gnt = vpu_req & ~cpu_req;
        end else if (cpu_req && (wait_cnt == WAIT_MAX)) begin
          cpu_gnt = 1'b1;
        end else begin
          vpu_gnt = vpu_req;
          cpu_gnt = cpu_req & ~vpu_req;
        end
        if (vpu_gnt && vpu_burst && (BURST_LEN > 1)) begin
          state_nxt     = BURST;
          burst_cnt_nxt = BURST_LOAD;
        end else begin
          state_nxt     = ARB;
          burst_cnt_nxt = burst_cnt;
        end
        if (cpu_gnt || !cpu_req) begin
          wait_cnt_nxt = {WCW{1'b0}};
        end else if (!vblank && (wait_cnt != WAIT_MAX)) begin
          wait_cnt_nxt = wait_cnt + WCW'(1);
        end else begin
          wait_cnt_nxt = wait_cnt;
        end
      end
      BURST: begin
        vpu_gnt = vpu_req;
        if (vpu_gnt) begin
          burst_cnt_nxt = burst_cnt - BCW'(1);
          if (burst_cnt == BURST_LAST) begin
            state_nxt = ARB;
          end else begin
            state_nxt = BURST;
          end
        end else begin
          burst_cnt_nxt = burst_cnt;
        end
      end
      default: begin
        state_nxt     = ARB;
        burst_cnt_nxt = {BCW{1'b0}};
        wait_cnt_nxt  = {WCW{1'b0}};
      end
    endcase
    if (!rst_n) begin
      vpu_gnt = 1'b0;
      cpu_gnt = 1'b0;
    end else begin
      vpu_gnt = vpu_gnt;
      cpu_gnt = cpu_gnt;
    end
  end

  assign ram_en    = vpu_gnt | cpu_gnt;
  assign ram_we    = cpu_gnt & cpu_we;
  assign ram_addr  = vpu_gnt ? vpu_addr : (cpu_gnt ? cpu_addr : {ADDR_W{1'b0}});
  assign ram_din   = cpu_gnt ? cpu_wdata : {DATA_W{1'b0}};
  assign vpu_rdata = ram_dout;
  assign cpu_rdata = ram_dout;

  // Arbiter state and read-return owner, which becomes the rvalid pulse one cycle after a read grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      burst_cnt  <= {BCW{1'b0}};
      wait_cnt   <= {WCW{1'b0}};
      vpu_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_cnt_nxt;
      wait_cnt   <= wait_cnt_nxt;
      vpu_rvalid <= vpu_gnt;
      cpu_rvalid <= cpu_gnt & ~cpu_we;
    end
  end

endmodule

// File: tb/tb_vpu_sp_ram_arbiter.sv
// Self-checking bench for vpu_sp_ram_arbiter: directed scenarios plus random
// traffic compared against a cycle-level reference of the arbitration rules.
module tb_vpu_sp_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BL = 20;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vblank, vpu_req, vpu_burst, cpu_req, cpu_we;
  logic [AW-1:0] vpu_addr, cpu_addr;
  logic [DW-1:0] cpu_wdata, vpu_rdata, cpu_rdata, ram_din, ram_dout;
  logic          vpu_gnt, vpu_rvalid, cpu_gnt, cpu_rvalid, ram_en, ram_we;
  logic [AW-1:0] ram_addr;

  vpu_sp_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .CPU_MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .vblank(vblank),
    .vpu_req(vpu_req), .vpu_burst(vpu_burst), .vpu_addr(vpu_addr),
    .vpu_gnt(vpu_gnt), .vpu_rvalid(vpu_rvalid), .vpu_rdata(vpu_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [AW-1:0] a);
    return ({22'h0, a} * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  // Single-port RAM with registered read data; unwritten words read a fixed pattern.
  logic [DW-1:0] mem [0:1023];
  bit            wr  [0:1023];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_din;
        wr[ram_addr]  <= 1'b1;
      end else begin
        ram_dout <= wr[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
      end
    end
  end

  int checks = 0;
  int errors = 0;
  bit m_burst;
  int m_left, m_wait;
  bit ev_rv, ec_rv;
  logic [31:0] ev_rd, ec_rd;
  logic [31:0] shadow [0:1023];
  bit vpu_done, cpu_done;
  bit obs_vg, obs_cg, obs_vrv, obs_crv;
  logic [31:0] obs_crd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare the DUT against the reference at negedge, then advance the reference.
  task automatic cyc();
    bit gv, gc;
    logic [31:0] ea, ed;
    @(negedge clk);
    gv = 1'b0;
    gc = 1'b0;
    if (rst_n) begin
      if (m_burst) gv = vpu_req;
      else if (vblank) begin gc = cpu_req; gv = vpu_req && !cpu_req; end
      else if (cpu_req && m_wait == MW - 1) gc = 1'b1;
      else begin gv = vpu_req; gc = cpu_req && !vpu_req; end
    end else begin
      ev_rv = 1'b0;
      ec_rv = 1'b0;
    end
    ea = gv ? 32'(vpu_addr) : (gc ? 32'(cpu_addr) : 32'h0);
    ed = gc ? cpu_wdata : 32'h0;
    chk("vpu_gnt", 32'(vpu_gnt), 32'(gv));
    chk("cpu_gnt", 32'(cpu_gnt), 32'(gc));
    chk("ram_en", 32'(ram_en), 32'(gv || gc));
    chk("ram_we", 32'(ram_we), 32'(gc && cpu_we));
    chk("ram_addr", 32'(ram_addr), ea);
    chk("ram_din", ram_din, ed);
    chk("vpu_rvalid", 32'(vpu_rvalid), 32'(ev_rv));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ec_rv));
    if (ev_rv) chk("vpu_rdata", vpu_rdata, ev_rd);
    if (ec_rv) chk("cpu_rdata", cpu_rdata, ec_rd);
    obs_vg = vpu_gnt; obs_cg = cpu_gnt;
    obs_vrv = vpu_rvalid; obs_crv = cpu_rvalid; obs_crd = cpu_rdata;
    if (!rst_n) begin
      m_burst = 1'b0; m_left = 0; m_wait = 0;
    end else begin
      ev_rv = gv;
      ec_rv = gc && !cpu_we;
      if (gv) ev_rd = shadow[vpu_addr];
      if (ec_rv) ec_rd = shadow[cpu_addr];
      if (gc && cpu_we) shadow[cpu_addr] = cpu_wdata;
      if (m_burst) begin
        if (gv) begin
          m_left--;
          if (m_left == 0) m_burst = 1'b0;
        end
      end else begin
        if (gv && vpu_burst && BL > 1) begin m_burst = 1'b1; m_left = BL - 1; end
        if (gc || !cpu_req) m_wait = 0;
        else if (!vblank && m_wait < MW - 1) m_wait++;
      end
    end
    vpu_done = gv;
    cpu_done = gc;
    @(posedge clk);
    #1;
  endtask

  // Random requesters that hold each request until the reference grants it.
  task automatic rnd(input int n, input int vb, input int vp, input int cp, input int bp);
    for (int i = 0; i < n; i++) begin
      vblank = (vb >= 2) ? 1'($urandom_range(1)) : 1'(vb);
      if (!vpu_req || vpu_done) begin
        vpu_req   = ($urandom_range(99) < vp);
        vpu_addr  = AW'($urandom_range(15));
        vpu_burst = ($urandom_range(99) < bp);
      end
      if (!cpu_req || cpu_done) begin
        cpu_req   = ($urandom_range(99) < cp);
        cpu_we    = 1'($urandom_range(1));
        cpu_addr  = AW'($urandom_range(15));
        cpu_wdata = $urandom;
      end
      cyc();
    end
  endtask

  initial begin
    int nv, nc, first_c;
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(AW'(i));
    m_burst = 1'b0; m_left = 0; m_wait = 0; ev_rv = 1'b0; ec_rv = 1'b0;
    ev_rd = 32'h0; ec_rd = 32'h0; vpu_done = 1'b0; cpu_done = 1'b0;
    rst_n = 1'b0; vblank = 1'b0; vpu_req = 1'b0; vpu_burst = 1'b0; cpu_req = 1'b0;
    cpu_we = 1'b0; vpu_addr = '0; cpu_addr = '0; cpu_wdata = '0;

    // Reset state, including requests raised while reset is held.
    cyc();
    vpu_req = 1'b1; cpu_req = 1'b1;
    cyc();
    vpu_req = 1'b0; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(); cyc();

    // Both request continuously in active display: 7 VPU grants then a forced CPU grant.
    vpu_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h003;
    nc = 0; first_c = -1;
    for (int i = 0; i < 24; i++) begin
      if (vpu_done) vpu_addr = AW'($urandom_range(15));
      cyc();
      if (obs_cg) begin
        nc++;
        if (first_c < 0) first_c = i;
      end
    end
    chk("starve_first_cpu", 32'(first_c), 32'd7);
    chk("starve_cpu_count", 32'(nc), 32'd3);

    // Vblank: CPU every cycle, then VPU immediately after vblank drops.
    vblank = 1'b1; nv = 0; nc = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      nv += int'(obs_vg); nc += int'(obs_cg);
    end
    chk("vblank_cpu_count", 32'(nc), 32'd6);
    chk("vblank_vpu_count", 32'(nv), 32'd0);
    vblank = 1'b0;
    cyc();
    chk("vblank_drop_vpu", 32'(obs_vg), 32'd1);
    vpu_req = 1'b0; cpu_req = 1'b0;
    cyc(); cyc();

    // Locked burst of 20 beats holds off a CPU write even once vblank rises.
    vpu_req = 1'b1; vpu_burst = 1'b1; vpu_addr = 10'h004;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h155; cpu_wdata = 32'h12345678;
    nv = 0; nc = 0;
    for (int t = 0; t < 20; t++) begin
      vblank = (t >= 3);
      cyc();
      vpu_burst = 1'b0;
      vpu_addr = AW'($urandom_range(15));
      nv += int'(obs_vg); nc += int'(obs_cg);
    end
    chk("burst_vpu_beats", 32'(nv), 32'd20);
    chk("burst_cpu_blocked", 32'(nc), 32'd0);
    cyc();
    chk("burst_end_cpu_gnt", 32'(obs_cg), 32'd1);
    chk("burst_wr_landed", mem[10'h155], 32'h12345678);
    vpu_req = 1'b0; cpu_req = 1'b0; vblank = 1'b0;
    cyc(); cyc();

    // CPU write then read-back of the same word.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h2A0; cpu_wdata = 32'hDEADBEEF;
    cyc();
    cpu_we = 1'b0; cpu_wdata = 32'h0;
    cyc();
    chk("rd_gnt", 32'(obs_cg), 32'd1);
    cpu_req = 1'b0;
    cyc();
    chk("rd_rvalid", 32'(obs_crv), 32'd1);
    chk("rd_rdata", obs_crd, 32'hDEADBEEF);
    chk("rd_no_vpu_rvalid", 32'(obs_vrv), 32'd0);

    // Reset in the middle of a burst abandons it.
    vpu_req = 1'b1; vpu_burst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h2A0;
    for (int t = 0; t < 10; t++) begin
      cyc();
      vpu_burst = 1'b0;
    end
    rst_n = 1'b0;
    for (int t = 0; t < 3; t++) cyc();
    rst_n = 1'b1; cpu_req = 1'b0; vpu_addr = 10'h007;
    cyc();
    chk("post_rst_vpu_gnt", 32'(obs_vg), 32'd1);
    vpu_req = 1'b0; cpu_req = 1'b1;
    cyc();
    chk("post_rst_cpu_gnt", 32'(obs_cg), 32'd1);
    chk("post_rst_vpu_rvalid", 32'(obs_vrv), 32'd1);
    cpu_req = 1'b0;
    cyc();

    // Randomised traffic across display, mixed and vblank phases.
    rnd(300, 0, 70, 60, 5);
    rnd(200, 2, 60, 60, 10);
    rnd(200, 1, 80, 80, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
